// File: rtl/cpe_lsu_if.sv
// Core-side request/response and data-memory strobe/ack signals of the load/store unit.
interface cpe_lsu_if;
    logic        req_w_i_h;
    logic        we_w_i_h;
    logic [2:0]  funct_3_w_i;
    logic [31:0] addr_w_i;
    logic [31:0] wr_data_w_i;
    logic        ready_w_o_h;
    logic        done_w_o_h;
    logic [31:0] rd_data_w_o;
    logic        misalign_w_o_h;
    logic        bus_err_w_o_h;
    logic [31:0] mem_addr_w_o;
    logic [31:0] mem_data_in_w_o;
    logic [3:0]  mem_byte_en_w_o;
    logic        mem_rd_w_o_h;
    logic        mem_wr_w_o_h;
    logic        mem_ack_w_i_h;
    logic [31:0] mem_data_w_i;

    // master: core plus memory (drives requests and acks); slave: the LSU
    modport master (
        output req_w_i_h, we_w_i_h, funct_3_w_i, addr_w_i, wr_data_w_i,
        output mem_ack_w_i_h, mem_data_w_i,
        input  ready_w_o_h, done_w_o_h, rd_data_w_o, misalign_w_o_h, bus_err_w_o_h,
        input  mem_addr_w_o, mem_data_in_w_o, mem_byte_en_w_o, mem_rd_w_o_h, mem_wr_w_o_h
    );
    modport slave (
        input  req_w_i_h, we_w_i_h, funct_3_w_i, addr_w_i, wr_data_w_i,
        input  mem_ack_w_i_h, mem_data_w_i,
        output ready_w_o_h, done_w_o_h, rd_data_w_o, misalign_w_o_h, bus_err_w_o_h,
        output mem_addr_w_o, mem_data_in_w_o, mem_byte_en_w_o, mem_rd_w_o_h, mem_wr_w_o_h
    );
endinterface

// File: rtl/cpe_lsu.sv
// RV32I load/store unit: lane setup, alignment check, strobe/ack bus cycle with
// timeout, and sign/zero extension of load data.
module cpe_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk_w_i,
    input  logic         res_w_i_h,
    cpe_lsu_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_we;
    logic [2:0]  r_funct;
    logic [1:0]  r_off;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_data;
    logic [3:0]  r_byte_en;
    logic [7:0]  r_cnt;
    logic [31:0] r_rd_data;
    logic        r_misalign;
    logic        r_bus_err;

    logic        w_bad;
    logic [3:0]  w_en;
    logic [31:0] w_din;
    logic        w_timeout;
    logic [31:0] w_load;
    logic [15:0] w_half;
    logic [7:0]  w_byte [4];

    // Request decode straight from the core inputs; only used on the accept cycle
    always_comb begin
        w_bad = 1'b0;
        w_en  = 4'b0001 << bus.addr_w_i[1:0];
        w_din = {4{bus.wr_data_w_i[7:0]}};
        case (bus.funct_3_w_i)
            3'b000: ;
            3'b100: w_bad = bus.we_w_i_h;
            3'b001, 3'b101: begin
                w_bad = bus.addr_w_i[0] | (bus.we_w_i_h & bus.funct_3_w_i[2]);
                w_en  = bus.addr_w_i[1] ? 4'b1100 : 4'b0011;
                w_din = {2{bus.wr_data_w_i[15:0]}};
            end
            3'b010: begin
                w_bad = |bus.addr_w_i[1:0];
                w_en  = 4'b1111;
                w_din = bus.wr_data_w_i;
            end
            default: w_bad = 1'b1;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_byte[gi] = bus.mem_data_w_i[8*gi +: 8];
        end
    endgenerate

    assign w_half = r_off[1] ? {w_byte[3], w_byte[2]} : {w_byte[1], w_byte[0]};

    always_comb begin
        w_load = 32'd0;
        case (r_funct)
            3'b000:  w_load = {{24{w_byte[r_off][7]}}, w_byte[r_off]};
            3'b100:  w_load = {24'd0, w_byte[r_off]};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            3'b010:  w_load = bus.mem_data_w_i;
            default: w_load = 32'd0;
        endcase
    end

    // Counter counts ACCESS cycles already spent without ack
    assign w_timeout = ({1'b0, r_cnt} + 9'd1) == 9'(TIMEOUT);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_w_i_h) w_state_next = w_bad ? RESP : ACCESS;
            ACCESS:  if (bus.mem_ack_w_i_h || w_timeout) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_w_i) begin
        if (res_w_i_h) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_funct    <= 3'd0;
            r_off      <= 2'd0;
            r_mem_addr <= 32'd0;
            r_mem_data <= 32'd0;
            r_byte_en  <= 4'd0;
            r_cnt      <= 8'd0;
            r_rd_data  <= 32'd0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: if (bus.req_w_i_h) begin
                    r_we       <= bus.we_w_i_h;
                    r_funct    <= bus.funct_3_w_i;
                    r_off      <= bus.addr_w_i[1:0];
                    r_misalign <= w_bad;
                    r_bus_err  <= 1'b0;
                    if (w_bad) begin
                        r_rd_data <= 32'd0;
                    end else begin
                        r_mem_addr <= {bus.addr_w_i[31:2], 2'b00};
                        r_mem_data <= w_din;
                        r_byte_en  <= w_en;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack_w_i_h) begin
                        r_rd_data <= r_we ? 32'd0 : w_load;
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                        r_rd_data <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    r_cnt      <= 8'd0;
                    r_misalign <= 1'b0;
                    r_bus_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_w_o_h     = (r_state == IDLE);
    assign bus.done_w_o_h      = (r_state == RESP);
    assign bus.rd_data_w_o     = r_rd_data;
    assign bus.misalign_w_o_h  = r_misalign;
    assign bus.bus_err_w_o_h   = r_bus_err;
    assign bus.mem_addr_w_o    = r_mem_addr;
    assign bus.mem_data_in_w_o = r_mem_data;
    assign bus.mem_byte_en_w_o = r_byte_en;
    assign bus.mem_rd_w_o_h    = (r_state == ACCESS) && !r_we;
    assign bus.mem_wr_w_o_h    = (r_state == ACCESS) && r_we;
endmodule
